// File: rtl/vga_wave_pkg.sv
// Shared geometry and FSM encoding for the VGA waveform RAM.
// Imported by the display-side reader and the ADC-to-RAM column writer.
// Pure constants/types; no logic.
package vga_wave_pkg;

   localparam int WAVE_COLS          = 640;
   localparam int WAVE_WORDS_PER_COL = 25;
   localparam int WAVE_TOP           = 40;
   localparam int WAVE_BOT           = 439;
   localparam int WAVE_ADDR_W        = 18;

   // RAM ownership state of the display reader
   typedef enum logic [1:0] {
      ST_WRITER = 2'd0,
      ST_TURN   = 2'd1,
      ST_READ   = 2'd2
   } wave_state_t;

endpackage

// File: rtl/vga_wave_addr_gen.sv
// Window check and column-major RAM address for one (HCNT, VCNT) pixel.
// Purely combinational: zero latency.
// No flow control; outputs follow the inputs.
module vga_wave_addr_gen
   import vga_wave_pkg::*;
(
   input  logic [9:0]             hcnt,
   input  logic [9:0]             vcnt,
   output logic                   in_window,
   output logic [WAVE_ADDR_W-1:0] addr,
   output logic [3:0]             bit_idx
);

   logic [9:0]             ry;
   logic [4:0]             word;
   logic [WAVE_ADDR_W-1:0] x_ext;

   // Flip the row so ry=0 is the bottom trace row, then x*25 via shift-add
   always_comb begin
      ry        = 10'(WAVE_BOT) - vcnt;
      word      = ry[8:4];
      bit_idx   = ry[3:0];
      in_window = (hcnt < 10'(WAVE_COLS)) &&
                  (vcnt >= 10'(WAVE_TOP)) &&
                  (vcnt <= 10'(WAVE_BOT));
      x_ext     = {8'd0, hcnt};
      addr      = (x_ext << 4) + (x_ext << 3) + x_ext + {13'd0, word};
   end

endmodule

// File: rtl/vga_wave_reader.sv
// Display-side waveform RAM reader: fetches one word per window pixel, emits one bit per pixel.
// Latency: address 1 CLK after PIX_EN, data sampled 1 CLK later, pixel out on next PIX_EN (2 CLK).
// Yields the RAM whenever VGA_RAM_ACCESS_OK is high; in-flight reads are dropped (WAVE_VALID=0).
module vga_wave_reader
   import vga_wave_pkg::*;
(
   input  logic                   CLK_50MHZ,
   input  logic                   MASTER_RST,
   input  logic                   PIX_EN,
   input  logic [9:0]             HCNT,
   input  logic [9:0]             VCNT,
   input  logic                   VGA_RAM_ACCESS_OK,
   input  logic [15:0]            VGA_RAM_DATA,
   output logic [WAVE_ADDR_W-1:0] VGA_RAM_ADDR,
   output logic                   VGA_RAM_OE,
   output logic                   VGA_RAM_WE,
   output logic                   VGA_RAM_CS,
   output logic                   WAVE_PIXEL,
   output logic                   WAVE_VALID
);

   wave_state_t            state;
   logic                   oe_q;
   logic                   in_window;
   logic [WAVE_ADDR_W-1:0] addr_calc;
   logic [3:0]             bit_calc;
   logic [3:0]             bit_q;
   logic [15:0]            data_q;
   logic                   issue;
   logic                   inflight;
   logic                   sample_pend;

   vga_wave_addr_gen u_addr_gen (
      .hcnt      (HCNT),
      .vcnt      (VCNT),
      .in_window (in_window),
      .addr      (addr_calc),
      .bit_idx   (bit_calc)
   );

   // A read starts only on a pixel strobe while we own the bus and the pixel is in the window
   assign issue = PIX_EN && (state == ST_READ) && !VGA_RAM_ACCESS_OK && in_window;

   // Writer can grab the bus at any edge; OE is forced off immediately to avoid contention
   assign VGA_RAM_OE = oe_q | VGA_RAM_ACCESS_OK;
   assign VGA_RAM_WE = 1'b1;
   assign VGA_RAM_CS = 1'b0;

   // Bus ownership FSM with one turnaround cycle before driving OE low
   always_ff @(posedge CLK_50MHZ) begin
      if (MASTER_RST) begin
         state <= ST_WRITER;
         oe_q  <= 1'b1;
      end else if (VGA_RAM_ACCESS_OK) begin
         state <= ST_WRITER;
         oe_q  <= 1'b1;
      end else begin
         case (state)
            ST_WRITER: begin
               state <= ST_TURN;
               oe_q  <= 1'b1;
            end
            ST_TURN: begin
               state <= ST_READ;
               oe_q  <= 1'b0;
            end
            ST_READ: begin
               state <= ST_READ;
               oe_q  <= 1'b0;
            end
            default: begin
               state <= ST_WRITER;
               oe_q  <= 1'b1;
            end
         endcase
      end
   end

   // Per-pixel pipeline: issue address, sample async SRAM data, present bit on next strobe
   always_ff @(posedge CLK_50MHZ) begin
      if (MASTER_RST) begin
         VGA_RAM_ADDR <= '0;
         bit_q        <= '0;
         data_q       <= '0;
         sample_pend  <= 1'b0;
         inflight     <= 1'b0;
         WAVE_PIXEL   <= 1'b0;
         WAVE_VALID   <= 1'b0;
      end else begin
         sample_pend <= issue;
         if (sample_pend && !VGA_RAM_ACCESS_OK) begin
            data_q <= VGA_RAM_DATA;
         end
         if (issue) begin
            VGA_RAM_ADDR <= addr_calc;
            bit_q        <= bit_calc;
         end
         if (PIX_EN) begin
            WAVE_VALID <= inflight && !VGA_RAM_ACCESS_OK;
            WAVE_PIXEL <= inflight && !VGA_RAM_ACCESS_OK && data_q[bit_q];
            inflight   <= issue;
         end else if (VGA_RAM_ACCESS_OK) begin
            inflight <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vga_wave_reader.sv
// Directed bench for vga_wave_reader with an async SRAM model and an exhaustive address-gen sweep.
// Each scenario task drives pixels and compares against hand-computed values.
// Prints one summary line at the end.
module tb_vga_wave_reader;
   import vga_wave_pkg::*;

   logic        clk;
   logic        rst;
   logic        pix_en;
   logic [9:0]  hcnt;
   logic [9:0]  vcnt;
   logic        ok;
   logic [15:0] ram_data;
   logic [17:0] ram_addr;
   logic        ram_oe;
   logic        ram_we;
   logic        ram_cs;
   logic        wave_pixel;
   logic        wave_valid;

   logic [9:0]  sw_h;
   logic [9:0]  sw_v;
   logic        sw_in;
   logic [17:0] sw_addr;
   logic [3:0]  sw_bit;

   logic [15:0] mem [0:15999];

   int tests;
   int failed;

   vga_wave_reader dut (
      .CLK_50MHZ         (clk),
      .MASTER_RST        (rst),
      .PIX_EN            (pix_en),
      .HCNT              (hcnt),
      .VCNT              (vcnt),
      .VGA_RAM_ACCESS_OK (ok),
      .VGA_RAM_DATA      (ram_data),
      .VGA_RAM_ADDR      (ram_addr),
      .VGA_RAM_OE        (ram_oe),
      .VGA_RAM_WE        (ram_we),
      .VGA_RAM_CS        (ram_cs),
      .WAVE_PIXEL        (wave_pixel),
      .WAVE_VALID        (wave_valid)
   );

   vga_wave_addr_gen u_ref (
      .hcnt      (sw_h),
      .vcnt      (sw_v),
      .in_window (sw_in),
      .addr      (sw_addr),
      .bit_idx   (sw_bit)
   );

   // Async SRAM: bus floats high when not output-enabled
   assign ram_data = (!ram_oe && ram_addr < 18'd16000) ? mem[ram_addr] : 16'hFFFF;

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pix_step(input logic [9:0] h, input logic [9:0] v);
      pix_en = 1'b1;
      hcnt   = h;
      vcnt   = v;
      tick();
      pix_en = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; ok = 1'b0; pix_en = 1'b0; hcnt = '0; vcnt = '0;
      tick();
      tick();
      tests++; if (ram_addr !== 18'd0) begin failed++; $display("FAIL reset_addr got %0d want 0", ram_addr); end
      tests++; if (ram_oe !== 1'b1) begin failed++; $display("FAIL reset_oe got %b want 1", ram_oe); end
      tests++; if (ram_we !== 1'b1 || ram_cs !== 1'b0) begin failed++; $display("FAIL reset_we_cs got %b%b want 10", ram_we, ram_cs); end
      tests++; if (wave_pixel !== 1'b0 || wave_valid !== 1'b0) begin failed++; $display("FAIL reset_wave got %b%b want 00", wave_pixel, wave_valid); end
      rst = 1'b0;
      tick();
      tests++; if (ram_oe !== 1'b1) begin failed++; $display("FAIL turn_oe got %b want 1", ram_oe); end
      tick();
      tests++; if (ram_oe !== 1'b0) begin failed++; $display("FAIL read_oe got %b want 0", ram_oe); end
   endtask

   task automatic test_window_edge();
      pix_step(10'd0, 10'd439);
      tests++; if (ram_addr !== 18'd0) begin failed++; $display("FAIL edge_addr got %0d want 0", ram_addr); end
      pix_step(10'd1, 10'd439);
      tests++; if (wave_pixel !== 1'b1 || wave_valid !== 1'b1) begin failed++; $display("FAIL edge_pixel got %b%b want 11", wave_pixel, wave_valid); end
      tests++; if (ram_addr !== 18'd25) begin failed++; $display("FAIL edge_addr2 got %0d want 25", ram_addr); end
   endtask

   task automatic test_top_right();
      pix_step(10'd639, 10'd40);
      tests++; if (ram_addr !== 18'd15999) begin failed++; $display("FAIL topright_addr got %0d want 15999", ram_addr); end
      pix_step(10'd639, 10'd41);
      tests++; if (wave_pixel !== 1'b1 || wave_valid !== 1'b1) begin failed++; $display("FAIL topright_pixel got %b%b want 11", wave_pixel, wave_valid); end
      tests++; if (ram_addr !== 18'd15999) begin failed++; $display("FAIL topright_addr41 got %0d want 15999", ram_addr); end
      pix_step(10'd0, 10'd439);
      tests++; if (wave_pixel !== 1'b0 || wave_valid !== 1'b1) begin failed++; $display("FAIL topright_v41 got %b%b want 01", wave_pixel, wave_valid); end
   endtask

   task automatic test_outside();
      pix_step(10'd10, 10'd439);
      pix_step(10'd5, 10'd39);
      tests++; if (wave_pixel !== 1'b1 || wave_valid !== 1'b1) begin failed++; $display("FAIL outside_prev got %b%b want 11", wave_pixel, wave_valid); end
      tests++; if (ram_addr !== 18'd250) begin failed++; $display("FAIL outside_addr39 got %0d want 250", ram_addr); end
      pix_step(10'd5, 10'd440);
      tests++; if (wave_pixel !== 1'b0 || wave_valid !== 1'b0) begin failed++; $display("FAIL outside_v39 got %b%b want 00", wave_pixel, wave_valid); end
      tests++; if (ram_addr !== 18'd250) begin failed++; $display("FAIL outside_addr440 got %0d want 250", ram_addr); end
      pix_step(10'd640, 10'd200);
      tests++; if (wave_pixel !== 1'b0 || wave_valid !== 1'b0) begin failed++; $display("FAIL outside_v440 got %b%b want 00", wave_pixel, wave_valid); end
      pix_step(10'd11, 10'd439);
      tests++; if (wave_valid !== 1'b0 || ram_addr !== 18'd275) begin failed++; $display("FAIL outside_h640 got valid=%b addr=%0d want 0/275", wave_valid, ram_addr); end
   endtask

   task automatic test_handover();
      pix_step(10'd100, 10'd200);
      pix_en = 1'b1; hcnt = 10'd101; vcnt = 10'd200;
      tick();
      tests++; if (wave_pixel !== 1'b1 || wave_valid !== 1'b1) begin failed++; $display("FAIL handover_pre got %b%b want 11", wave_pixel, wave_valid); end
      ok = 1'b1;
      #1;
      tests++; if (ram_oe !== 1'b1) begin failed++; $display("FAIL handover_oe_comb got %b want 1", ram_oe); end
      pix_en = 1'b0;
      tick();
      pix_step(10'd102, 10'd200);
      tests++; if (wave_valid !== 1'b0 || ram_addr !== 18'd2539) begin failed++; $display("FAIL handover_slot got valid=%b addr=%0d want 0/2539", wave_valid, ram_addr); end
      ok = 1'b0;
      tick();
      tests++; if (ram_oe !== 1'b1 || dut.state !== ST_TURN) begin failed++; $display("FAIL handover_turn got oe=%b state=%0d want 1/%0d", ram_oe, dut.state, ST_TURN); end
      tick();
      tests++; if (ram_oe !== 1'b0) begin failed++; $display("FAIL handover_read_oe got %b want 0", ram_oe); end
      pix_step(10'd103, 10'd200);
      tests++; if (ram_addr !== 18'd2589) begin failed++; $display("FAIL handover_resume_addr got %0d want 2589", ram_addr); end
      pix_step(10'd104, 10'd200);
      tests++; if (wave_pixel !== 1'b1 || wave_valid !== 1'b1) begin failed++; $display("FAIL handover_resume_pix got %b%b want 11", wave_pixel, wave_valid); end
   endtask

   task automatic test_simultaneous();
      pix_step(10'd200, 10'd100);
      pix_en = 1'b1; hcnt = 10'd201; vcnt = 10'd100; ok = 1'b1;
      tick();
      tests++; if (ram_addr !== 18'd5021 || ram_oe !== 1'b1) begin failed++; $display("FAIL simul_noissue got addr=%0d oe=%b want 5021/1", ram_addr, ram_oe); end
      pix_en = 1'b0;
      tick();
      ok = 1'b0;
      tick();
      tick();
      pix_step(10'd202, 10'd100);
      tests++; if (wave_valid !== 1'b0 || ram_addr !== 18'd5071) begin failed++; $display("FAIL simul_slot got valid=%b addr=%0d want 0/5071", wave_valid, ram_addr); end
      pix_step(10'd203, 10'd100);
      tests++; if (wave_pixel !== 1'b1 || wave_valid !== 1'b1) begin failed++; $display("FAIL simul_after got %b%b want 11", wave_pixel, wave_valid); end
   endtask

   task automatic test_reset_mid_read();
      pix_step(10'd300, 10'd439);
      tests++; if (ram_addr !== 18'd7500) begin failed++; $display("FAIL rstmid_addr_pre got %0d want 7500", ram_addr); end
      pix_en = 1'b1; hcnt = 10'd301; rst = 1'b1;
      tick();
      tests++; if (ram_addr !== 18'd0 || ram_oe !== 1'b1 || wave_valid !== 1'b0 || dut.state !== ST_WRITER) begin
         failed++; $display("FAIL rstmid_edge got addr=%0d oe=%b valid=%b state=%0d want 0/1/0/%0d", ram_addr, ram_oe, wave_valid, dut.state, ST_WRITER);
      end
      pix_en = 1'b0;
      tick();
      tests++; if (ram_addr !== 18'd0 || ram_oe !== 1'b1 || wave_valid !== 1'b0 || wave_pixel !== 1'b0) begin
         failed++; $display("FAIL rstmid_hold got addr=%0d oe=%b valid=%b pix=%b", ram_addr, ram_oe, wave_valid, wave_pixel);
      end
      rst = 1'b0;
      tick();
      tests++; if (dut.state !== ST_TURN || ram_oe !== 1'b1) begin failed++; $display("FAIL rstmid_turn got state=%0d oe=%b", dut.state, ram_oe); end
      tick();
      tests++; if (dut.state !== ST_READ || ram_oe !== 1'b0) begin failed++; $display("FAIL rstmid_read got state=%0d oe=%b", dut.state, ram_oe); end
   endtask

   task automatic test_addr_gen_sweep();
      int errs;
      int exp_addr;
      errs = 0;
      for (int x = 0; x < 640; x++) begin
         for (int ry = 0; ry < 400; ry++) begin
            sw_h = 10'(x);
            sw_v = 10'(439 - ry);
            #1;
            exp_addr = x * 25 + ry / 16;
            if (sw_in !== 1'b1 || sw_addr !== 18'(exp_addr) || sw_bit !== 4'(ry % 16)) begin
               if (errs == 0) $display("FAIL addrgen_sweep x=%0d ry=%0d got addr=%0d bit=%0d in=%b want %0d/%0d/1", x, ry, sw_addr, sw_bit, sw_in, exp_addr, ry % 16);
               errs++;
            end
         end
      end
      tests++; if (errs != 0) failed++;
      errs = 0;
      for (int i = 0; i < 6; i++) begin
         case (i)
            0: begin sw_h = 10'd0;    sw_v = 10'd39;   end
            1: begin sw_h = 10'd639;  sw_v = 10'd440;  end
            2: begin sw_h = 10'd640;  sw_v = 10'd200;  end
            3: begin sw_h = 10'd1023; sw_v = 10'd40;   end
            4: begin sw_h = 10'd5;    sw_v = 10'd0;    end
            default: begin sw_h = 10'd5; sw_v = 10'd1023; end
         endcase
         #1;
         if (sw_in !== 1'b0) begin
            $display("FAIL addrgen_outside h=%0d v=%0d got in=%b want 0", sw_h, sw_v, sw_in);
            errs++;
         end
      end
      tests++; if (errs != 0) failed++;
   endtask

   initial begin
      tests  = 0;
      failed = 0;
      rst = 1'b1; ok = 1'b1; pix_en = 1'b0; hcnt = '0; vcnt = '0;
      sw_h = '0; sw_v = '0;
      for (int i = 0; i < 16000; i++) mem[i] = 16'h0000;
      mem[0]     = 16'h0001;
      mem[15999] = 16'h8000;
      mem[250]   = 16'h0001;
      mem[2514]  = 16'h8000;
      mem[2589]  = 16'h8000;
      mem[5071]  = 16'h0008;

      test_reset();
      test_window_edge();
      test_top_right();
      test_outside();
      test_handover();
      test_simultaneous();
      test_reset_mid_read();
      test_addr_gen_sweep();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/vga_wave_reader.md
# vga_wave_reader

Display-side reader for the VGA waveform RAM. During active video it fetches the column-major waveform words and serialises one bit per pixel into a registered waveform-pixel output for the colour mixer. The RAM layout is 25 words of 16 bits per screen column, at address = column*25 + word. The block owns the RAM port only while VGA_RAM_ACCESS_OK is low; the ADC-to-RAM column writer owns it while that signal is high.

## Interface
- No parameters. Geometry constants are fixed in the shared package.
- CLK_50MHZ  in  1  system clock
- MASTER_RST  in  1  system reset; one clock, reset is synchronous and active-high
- PIX_EN  in  1  pixel strobe from the sync generator, high one cycle in two (25 MHz)
- HCNT  in  10  horizontal pixel count, valid with PIX_EN
- VCNT  in  10  vertical line count, valid with PIX_EN
- VGA_RAM_ACCESS_OK  in  1  high = writer owns the RAM; low = this block may read
- VGA_RAM_DATA  in  16  asynchronous SRAM read data
- VGA_RAM_ADDR  out  18  read address
- VGA_RAM_OE  out  1  output enable, active low
- VGA_RAM_WE  out  1  write enable, active low; constant 1
- VGA_RAM_CS  out  1  chip select, active low; constant 0
- WAVE_PIXEL  out  1  waveform bit for the pixel presented on the previous PIX_EN
- WAVE_VALID  out  1  WAVE_PIXEL corresponds to a waveform-window pixel

## Operation
- Waveform window
  - Columns x = HCNT, 0..639.
  - Rows VCNT 40..439; value ry = 439 − VCNT, range 0..399.
  - word = ry[8:4] (0..24); bit = ry[3:0]; bit 0 is the lowest trace row of the word.
- Address: VGA_RAM_ADDR = (x<<4) + (x<<3) + x + word, zero-extended to 18 bits. Maximum value is 15999.
- FSM, states WRITER, TURN, READ:
  - Reset state is WRITER.
  - WRITER → TURN when VGA_RAM_ACCESS_OK is low.
  - TURN → READ after exactly one CLK_50MHZ cycle. This is bus turnaround while the writer releases the data bus.
  - Any state → WRITER on the clock edge where VGA_RAM_ACCESS_OK is high.
- VGA_RAM_OE
  - Registered: low only in READ.
  - Additionally forced high combinationally whenever VGA_RAM_ACCESS_OK is high, so there is no contention cycle.
- Pipeline (per pixel)
  - S0, on PIX_EN in READ with the pixel in the window: register the address and bit index; set the in-flight flag.
  - S1, next CLK: sample VGA_RAM_DATA into the data register.
  - S2, next PIX_EN: WAVE_PIXEL = data[bit]; WAVE_VALID = in-flight flag.
- A pixel outside the window, or one presented in WRITER or TURN, gives WAVE_PIXEL=0 and WAVE_VALID=0 on its output slot. VGA_RAM_ADDR holds its last value.
- Entering WRITER clears the in-flight flag, so a read interrupted mid-pipeline produces WAVE_VALID=0.
- Reset values: VGA_RAM_ADDR=0, VGA_RAM_OE=1, VGA_RAM_WE=1, VGA_RAM_CS=0, WAVE_PIXEL=0, WAVE_VALID=0, FSM=WRITER, data register=0.

## Timing
- Address is valid 1 CLK after the PIX_EN edge that presents (HCNT, VCNT).
- Data is sampled 1 CLK later, giving 20 ns of SRAM access.
- Pixel output updates on the following PIX_EN edge. Latency is exactly one pixel (2 CLK).
- The sync generator delays HSYNC/VSYNC and blanking by one pixel to match.
- PIX_EN must alternate. Back-to-back PIX_EN is illegal; behaviour is then unspecified, but the block must not hang.
- VGA_RAM_ACCESS_OK falling: the first read address is issued on the first PIX_EN at least 1 CLK after the block is in READ.
- VGA_RAM_ACCESS_OK rising: OE goes high the same cycle, combinationally.
- Reset asserted mid-line overrides everything at the next edge. Outputs take reset values at that edge and hold them while MASTER_RST is high.
- Simultaneous PIX_EN and VGA_RAM_ACCESS_OK rising: no read is issued, and the slot outputs WAVE_VALID=0.

## Structure
- Shared package `vga_wave_pkg`:
  - constants WAVE_COLS=640, WAVE_WORDS_PER_COL=25, WAVE_TOP=40, WAVE_BOT=439;
  - FSM state encoding.
- The column writer imports the same constants.
- Natural sub-module: `vga_wave_addr_gen`, the combinational window check plus the ×25 shift-add address generator, so it can be unit-checked exhaustively.

## Test plan
- Window edge: preload word 0 = 16'h0001. With ACCESS_OK=0, present HCNT=0, VCNT=439 → ADDR=0. One pixel later, WAVE_PIXEL=1 and WAVE_VALID=1.
- Top-right word: word 15999 = 16'h8000. Present HCNT=639, VCNT=40 (ry=399, word 24, bit 15) → ADDR=15999 and WAVE_PIXEL=1. At VCNT=41, WAVE_PIXEL=0.
- Outside the window: VCNT=39 and VCNT=440, any HCNT → no change on ADDR, WAVE_VALID=0, WAVE_PIXEL=0.
- Handover: raise ACCESS_OK mid-line at HCNT=100.
  - OE=1 in the same cycle; the next slot gives WAVE_VALID=0.
  - Drop ACCESS_OK: exactly one TURN cycle, then OE=0; reads resume at the current HCNT.
- Reset during READ at HCNT=300: the next edge gives ADDR=0, OE=1, WAVE_VALID=0 and FSM=WRITER. After reset releases with ACCESS_OK=0, the block enters TURN, then READ.
- Exhaustive sweep of `vga_wave_addr_gen` over all (x, ry): the address equals x*25 + ry/16 against a reference model.
